// File: rtl/mem_loader_if.sv
// Byte-stream loader bus: load request, byte handshake and memory write port.
// The loader takes the slave modport; whoever feeds it takes the master modport.
interface mem_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic              we;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, word_count, in_byte, in_valid,
    input  in_ready, a, d, we, busy, done
  );

  modport slave (
    input  start, base_addr, word_count, in_byte, in_valid,
    output in_ready, a, d, we, busy, done
  );
endinterface

// File: rtl/mem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to
// consecutive (wrapping) addresses of a 2^ADDR_W-word memory.
module mem_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     r_widx;
  logic [1:0]          r_bidx;
  logic [DATA_W-1:0]   r_word;
  logic [ADDR_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_d;
  logic                r_we;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W:0]     w_count_clamped;

  assign w_count_clamped = (bus.word_count > MAX_WORDS) ? MAX_WORDS : bus.word_count;

  // All outputs are registered; each is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_count    <= '0;
      r_widx     <= '0;
      r_bidx     <= '0;
      r_word     <= '0;
      r_a        <= '0;
      r_d        <= '0;
      r_we       <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base  <= bus.base_addr;
            r_count <= w_count_clamped;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_busy  <= 1'b1;
            if (bus.word_count != '0) begin
              r_state    <= S_RECV;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (bus.in_valid) begin
            r_word[{r_bidx, 3'b000} +: 8] <= bus.in_byte;
            r_bidx <= r_bidx + 2'd1;
            // Last byte goes straight into d so the word is complete during WRITE.
            if (r_bidx == 2'd3) begin
              r_state    <= S_WRITE;
              r_in_ready <= 1'b0;
              r_we       <= 1'b1;
              r_a        <= r_base + r_widx[ADDR_W-1:0];
              r_d        <= {bus.in_byte, r_word[DATA_W-9:0]};
            end
          end
        end
        S_WRITE: begin
          if (r_widx == r_count - ONE_WORD) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_widx     <= r_widx + ONE_WORD;
            r_state    <= S_RECV;
            r_in_ready <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a        = r_a;
  assign bus.d        = r_d;
  assign bus.we       = r_we;
  assign bus.in_ready = r_in_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized directed bench for mem_loader: a memory model and write log are
// filled from the bus, and expected writes are derived from the byte stream.
module tb_mem_loader;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_loader_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  mem_loader #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [512];
  logic [8:0]  wr_a[$];
  logic [31:0] wr_d[$];
  int busy_cycles = 0;
  int done_cnt    = 0;
  int rw_viol     = 0;
  int we_run      = 0;
  logic we_prev   = 1'b0;

  always @(negedge clk) begin
    if (bus.busy) busy_cycles++;
    if (bus.done) done_cnt++;
    if (bus.we) begin
      wr_a.push_back(bus.a);
      wr_d.push_back(bus.d);
      mem[bus.a] = bus.d;
      if (bus.in_ready) rw_viol++;
      if (we_prev) we_run++;
    end
    we_prev = bus.we;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input bq_t b, input int k);
    return {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
  endfunction

  task automatic clear_mon();
    busy_cycles = 0;
    done_cnt    = 0;
    rw_viol     = 0;
    we_run      = 0;
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic do_start(input logic [8:0] base, input logic [9:0] wc);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = wc;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  task automatic stream(input bq_t bytes, input int n, input int prob,
                        input int rep_at, input logic [8:0] rep_base, output bit ok);
    int idx = 0;
    int cyc = 0;
    bit xfer;
    bit rep_done = 1'b0;
    while (idx < n && cyc < 20000) begin
      bus.in_valid = ($urandom_range(99) < prob);
      bus.in_byte  = bus.in_valid ? bytes[idx] : 8'($urandom);
      if (idx == rep_at && !rep_done) begin
        bus.start      = 1'b1;
        bus.base_addr  = rep_base;
        bus.word_count = 10'd1;
        rep_done       = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      xfer = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (xfer) idx++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    ok = (idx == n);
  endtask

  task automatic wait_idle(output bit ok);
    int cyc = 0;
    while (bus.busy && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = !bus.busy;
  endtask

  task automatic load(input string tag, input logic [8:0] base, input logic [9:0] wc,
                      input bq_t bytes, input int prob, input int rep_at,
                      input logic [8:0] rep_base);
    int n;
    bit ok;
    logic [8:0] ea;
    n = (wc > 10'd512) ? 512 : int'(wc);
    clear_mon();
    do_start(base, wc);
    stream(bytes, 4*n, prob, rep_at, rep_base, ok);
    check({tag, "/stream"}, ok, 1);
    wait_idle(ok);
    check({tag, "/idle"}, ok, 1);
    check({tag, "/nwrites"}, wr_a.size(), n);
    for (int k = 0; k < n; k++) begin
      ea = 9'((int'(base) + k) % 512);
      check({tag, "/a"}, wr_a[k], ea);
      check({tag, "/d"}, wr_d[k], word_of(bytes, k));
      check({tag, "/mem"}, mem[ea], word_of(bytes, k));
    end
    check({tag, "/done_pulses"}, done_cnt, 1);
    check({tag, "/ready_in_write"}, rw_viol, 0);
    check({tag, "/we_single"}, we_run, 0);
    check({tag, "/busy_end"}, bus.busy, 0);
    if (prob == 100) check({tag, "/cycles"}, busy_cycles, n*5 + 1);
  endtask

  initial begin
    bq_t b;
    bit ok;
    logic [8:0] rb;
    logic [9:0] rw;

    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.in_byte    = '0;
    bus.in_valid   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst/in_ready", bus.in_ready, 0);
    check("rst/we",       bus.we,       0);
    check("rst/busy",     bus.busy,     0);
    check("rst/done",     bus.done,     0);
    check("rst/a",        bus.a,        0);
    check("rst/d",        bus.d,        0);
    rst = 1'b0;

    // Four words, one significant byte each, streamed back to back.
    b = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'hB0, 8'h00, 8'h00, 8'h00,
          8'hC0, 8'h00, 8'h00, 8'h00, 8'hD0, 8'h00, 8'h00, 8'h00};
    load("basic", 9'd1, 10'd4, b, 100, -1, 9'd0);
    check("basic/d0", wr_d[0], 32'hA0);
    check("basic/d3", wr_d[3], 32'hD0);

    b.delete();
    for (int i = 1; i <= 12; i++) b.push_back(8'(i));
    load("wrap3", 9'd510, 10'd3, b, 100, -1, 9'd0);
    check("wrap3/w510", mem[510], 32'h04030201);
    check("wrap3/w0",   mem[0],   32'h0C0B0A09);

    b.delete();
    load("zero", 9'd5, 10'd0, b, 100, -1, 9'd0);

    b = '{8'h44, 8'h33, 8'h22, 8'h11};
    load("gappy", 9'd300, 10'd1, b, 50, -1, 9'd0);
    check("gappy/d", wr_d[0], 32'h11223344);

    b.delete();
    for (int i = 0; i < 16; i++) b.push_back(8'($urandom));
    load("wrap4", 9'd510, 10'd4, b, 100, -1, 9'd0);

    b.delete();
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
    load("restart", 9'd20, 10'd3, b, 100, 5, 9'd100);

    for (int t = 0; t < 4; t++) begin
      rb = 9'($urandom_range(511));
      rw = 10'($urandom_range(6, 1));
      b.delete();
      for (int i = 0; i < 4*int'(rw); i++) b.push_back(8'($urandom));
      load("rand", rb, rw, b, int'($urandom_range(100, 30)), -1, 9'd0);
    end

    b.delete();
    for (int i = 0; i < 2048; i++) b.push_back(8'($urandom));
    load("clamp", 9'd77, 10'd700, b, 100, -1, 9'd0);

    // Abort a two-word load partway through the second word.
    b.delete();
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom_range(255, 1)));
    clear_mon();
    do_start(9'd7, 10'd2);
    stream(b, 6, 100, -1, 9'd0, ok);
    check("abort/stream", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("abort/in_ready", bus.in_ready, 0);
    check("abort/we",       bus.we,       0);
    check("abort/busy",     bus.busy,     0);
    check("abort/done",     bus.done,     0);
    check("abort/a",        bus.a,        0);
    check("abort/d",        bus.d,        0);
    check("abort/nwrites",  wr_a.size(),  1);
    check("abort/a0",       wr_a[0],      9'd7);
    check("abort/d0",       wr_d[0],      word_of(b, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort/idle_after", bus.busy, 0);
    check("abort/no_more_writes", wr_a.size(), 1);
    check("abort/mem_kept", mem[7], word_of(b, 0));

    b.delete();
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    load("after_abort", 9'd0, 10'd2, b, 100, -1, 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
